// File: rtl/conv_pkg.sv
// Shared widths, rounding constant and signed datapath types for the 3x3 convolution engine.
// The rounding/saturation option (CONV_ROUND_EN) is selected in conv_engine.
package conv_pkg;

  localparam int BIT_LEN   = 8;
  localparam int CONV_LEN  = 20;
  localparam int CONV_LPOS = 13;
  localparam int M_LEN     = 3;
  localparam int PROD_LEN  = 2 * BIT_LEN;
  localparam int TRUNC_LSB = CONV_LEN - CONV_LPOS;

  typedef logic signed [BIT_LEN-1:0]   pix_t;
  typedef logic signed [BIT_LEN-1:0]   coef_t;
  typedef logic signed [PROD_LEN-1:0]  prod_t;
  typedef logic signed [CONV_LEN-1:0]  acc_t;
  typedef logic signed [CONV_LPOS-1:0] out_t;

  // One image/kernel column, index 0 = top row.
  typedef pix_t col_t [M_LEN];

  // Half an output LSB, added before truncation when rounding is enabled.
  localparam acc_t ROUND_CONST = acc_t'(1) <<< (TRUNC_LSB - 1);
  localparam out_t OUT_MAX     = {1'b0, {(CONV_LPOS-1){1'b1}}};

endpackage

// File: rtl/conv_mac3.sv
// One kernel column: registers the three signed pixel*coefficient products and
// presents their sign-extended sum to the top-level adder.
module conv_mac3
  import conv_pkg::*;
(
  input  logic CLK100MHZ,
  input  logic rst,
  input  logic en,
  input  col_t pix,
  input  col_t coef,
  output acc_t partial
);

  prod_t prod [M_LEN];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < M_LEN; r++) prod[r] <= '0;
    end else if (en) begin
      for (int r = 0; r < M_LEN; r++) prod[r] <= prod_t'(pix[r]) * prod_t'(coef[r]);
    end
  end

  // NOTE: the output gets a default before the loop so no latch is inferred.
  always_comb begin
    partial = '0;
    for (int r = 0; r < M_LEN; r++) partial = partial + acc_t'(prod[r]);
  end

endmodule

// File: rtl/conv_engine.sv
// Streaming 3x3 signed convolution: kernel/window column shift registers, product
// stage (conv_mac3 x3) and a registered output; CONV_ROUND_EN selects round+saturate.
module conv_engine
  import conv_pkg::*;
(
  input  logic                        CLK100MHZ,
  input  logic                        i_reset,
  input  logic                        i_valid,
  input  logic                        i_selecK_I,
  input  logic signed [BIT_LEN-1:0]   i_dato0,
  input  logic signed [BIT_LEN-1:0]   i_dato1,
  input  logic signed [BIT_LEN-1:0]   i_dato2,
  output logic signed [CONV_LPOS-1:0] o_data
);

  logic en_img;
  logic en_ker;
  col_t new_col;
  col_t kern [M_LEN];
  col_t win  [M_LEN];
  acc_t partial [M_LEN];
  acc_t sum_all;
  out_t o_next;

  assign en_img  = i_valid & i_selecK_I;
  assign en_ker  = i_valid & ~i_selecK_I;
  assign new_col = '{i_dato0, i_dato1, i_dato2};

  // NOTE: kernel and window are small flop arrays, not RAM, so they clear with the rest of the pipeline.
  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < M_LEN; c++) begin
        for (int r = 0; r < M_LEN; r++) begin
          kern[c][r] <= '0;
          win[c][r]  <= '0;
        end
      end
    end else if (en_img) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= new_col;
    end else if (en_ker) begin
      kern[0] <= kern[1];
      kern[1] <= kern[2];
      kern[2] <= new_col;
    end
  end

  for (genvar c = 0; c < M_LEN; c++) begin : g_col
    conv_mac3 u_mac (
      .CLK100MHZ (CLK100MHZ),
      .rst       (i_reset),
      .en        (en_img),
      .pix       (win[c]),
      .coef      (kern[c]),
      .partial   (partial[c])
    );
  end

  assign sum_all = partial[0] + partial[1] + partial[2];

`ifdef CONV_ROUND_EN
  logic signed [CONV_LEN:0] rnd_w;

  // One guard bit above the accumulator keeps the +half-LSB from wrapping.
  always_comb begin
    rnd_w = (CONV_LEN+1)'(sum_all) + (CONV_LEN+1)'(ROUND_CONST);
    if ((rnd_w >>> TRUNC_LSB) > (CONV_LEN+1)'(OUT_MAX)) o_next = OUT_MAX;
    else                                                o_next = out_t'(rnd_w >>> TRUNC_LSB);
  end
`else
  assign o_next = out_t'(sum_all >>> TRUNC_LSB);
`endif

  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset)     o_data <= '0;
    else if (en_img) o_data <= o_next;
  end

endmodule

// File: tb/tb_conv_engine.sv
// Self-checking bench for conv_engine: directed kernel/image vectors plus randomized
// streams checked against an integer 3x3 convolution model with 2-column latency.
module tb_conv_engine;

  logic              CLK100MHZ = 1'b0;
  logic              i_reset   = 1'b1;
  logic              i_valid   = 1'b0;
  logic              i_selecK_I = 1'b0;
  logic signed [7:0] i_dato0   = '0;
  logic signed [7:0] i_dato1   = '0;
  logic signed [7:0] i_dato2   = '0;
  logic signed [12:0] o_data;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: kernel and window as [row][col], col 2 newest.
  int mk [3][3];
  int mw [3][3];
  int m_prod;
  int m_out;

  conv_engine dut (
    .CLK100MHZ  (CLK100MHZ),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_selecK_I (i_selecK_I),
    .i_dato0    (i_dato0),
    .i_dato1    (i_dato1),
    .i_dato2    (i_dato2),
    .o_data     (o_data)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int scale(input int s);
`ifdef CONV_ROUND_EN
    int v;
    v = (s + 64) >>> 7;
    return (v > 4095) ? 4095 : v;
`else
    return s >>> 7;
`endif
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        mk[r][c] = 0;
        mw[r][c] = 0;
      end
    m_prod = 0;
    m_out  = 0;
  endfunction

  // Result emerges two image columns after its window completes; the product
  // stage uses whatever kernel is loaded when it captures the window.
  function automatic void model_edge(input logic sel, input int d0, input int d1, input int d2);
    int d [3];
    int acc;
    d = '{d0, d1, d2};
    if (sel) begin
      m_out = scale(m_prod);
      acc = 0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) acc += mw[r][c] * mk[r][c];
      m_prod = acc;
      for (int r = 0; r < 3; r++) begin
        mw[r][0] = mw[r][1];
        mw[r][1] = mw[r][2];
        mw[r][2] = d[r];
      end
    end else begin
      for (int r = 0; r < 3; r++) begin
        mk[r][0] = mk[r][1];
        mk[r][1] = mk[r][2];
        mk[r][2] = d[r];
      end
    end
  endfunction

  // Called at a negedge; drives, lets one rising edge pass, returns at the next negedge.
  task automatic step(input logic v, input logic sel, input int d0, input int d1, input int d2);
    i_valid    = v;
    i_selecK_I = sel;
    i_dato0    = 8'(d0);
    i_dato1    = 8'(d1);
    i_dato2    = 8'(d2);
    @(posedge CLK100MHZ);
    if (v) model_edge(sel, int'(i_dato0), int'(i_dato1), int'(i_dato2));
    @(negedge CLK100MHZ);
  endtask

  function automatic int rnd_pix();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic do_reset();
    i_reset = 1'b1;
    i_valid = 1'b0;
    #1;
    model_reset();
    @(negedge CLK100MHZ);
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    int exp_ones;
`ifdef CONV_ROUND_EN
    exp_ones = 9;
`else
    exp_ones = 8;
`endif
    model_reset();
    @(negedge CLK100MHZ);
    compared++;
    if (o_data !== 13'sd0) begin
      mismatched++;
      $display("FAIL reset_initial: o_data=%0d expected 0", o_data);
    end
    i_reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1, 1, 1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 127, 127, 127);
    compared++;
    if (int'(o_data) !== exp_ones) begin
      mismatched++;
      $display("FAIL reset_prestream: o_data=%0d expected %0d", o_data, exp_ones);
    end
    // Asynchronous assertion between clock edges.
    #2 i_reset = 1'b1;
    #1;
    model_reset();
    compared++;
    if (o_data !== 13'sd0) begin
      mismatched++;
      $display("FAIL reset_async: o_data=%0d expected 0 without clock edge", o_data);
    end
    @(negedge CLK100MHZ);
    i_reset = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1, 1, 1);
    compared++;
    if (o_data !== 13'sd0) begin
      mismatched++;
      $display("FAIL reset_kernel_cleared: o_data=%0d expected 0", o_data);
    end
  endtask

  task automatic test_center_tap();
    do_reset();
    step(1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 1'b0, 0, 64, 0);
    step(1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 1'b1, 0, 0, 0);
    step(1'b1, 1'b1, 0, 100, 0);
    step(1'b1, 1'b1, 0, 0, 0);
    step(1'b1, 1'b1, 0, 0, 0);
    compared++;
    if (o_data === 13'sd50) begin
      mismatched++;
      $display("FAIL center_tap_early: o_data=%0d one edge too early", o_data);
    end
    step(1'b1, 1'b1, 0, 0, 0);
    compared++;
    if (o_data !== 13'sd50) begin
      mismatched++;
      $display("FAIL center_tap: o_data=%0d expected 50", o_data);
    end
  endtask

  task automatic test_ones();
    int exp_v;
`ifdef CONV_ROUND_EN
    exp_v = 9;
`else
    exp_v = 8;
`endif
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1, 1, 1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 127, 127, 127);
    compared++;
    if (int'(o_data) !== exp_v) begin
      mismatched++;
      $display("FAIL ones_127: o_data=%0d expected %0d", o_data, exp_v);
    end
  endtask

  task automatic test_extremes();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, -128, -128, -128);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, -128, -128, -128);
    compared++;
    if (o_data !== 13'sd1152) begin
      mismatched++;
      $display("FAIL extreme_pos: o_data=%0d expected 1152", o_data);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 127, 127, 127);
    compared++;
    if (o_data !== 13'h1B89) begin
      mismatched++;
      $display("FAIL extreme_neg: o_data=0x%h expected 0x1B89 (-1143)", o_data);
    end
  endtask

  task automatic test_stall();
    logic signed [12:0] held;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rnd_pix(), rnd_pix(), rnd_pix());
    for (int col = 0; col < 8; col++) begin
      step(1'b1, 1'b1, rnd_pix(), rnd_pix(), rnd_pix());
      compared++;
      if (int'(o_data) !== m_out) begin
        mismatched++;
        $display("FAIL stall_col%0d: o_data=%0d expected %0d", col, o_data, m_out);
      end
      held = 13'(m_out);
      for (int s = 0; s < 5; s++) begin
        step(1'b0, 1'($urandom_range(0, 1)), rnd_pix(), rnd_pix(), rnd_pix());
        compared++;
        if (o_data !== held) begin
          mismatched++;
          $display("FAIL stall_hold%0d_%0d: o_data=%0d expected %0d", col, s, o_data, held);
        end
      end
    end
  endtask

  task automatic test_reload();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 0, 0, 0);
      compared++;
      if (int'(o_data) !== m_out) begin
        mismatched++;
        $display("FAIL reload_freeze%0d: o_data=%0d expected %0d", i, o_data, m_out);
      end
    end
    step(1'b1, 1'b1, rnd_pix(), rnd_pix(), rnd_pix());
    compared++;
    if (int'(o_data) !== m_out) begin
      mismatched++;
      $display("FAIL reload_resume1: o_data=%0d expected %0d", o_data, m_out);
    end
    step(1'b1, 1'b1, rnd_pix(), rnd_pix(), rnd_pix());
    compared++;
    if (o_data !== 13'sd0) begin
      mismatched++;
      $display("FAIL reload_zero: o_data=%0d expected 0", o_data);
    end
  endtask

  task automatic test_random();
    logic v;
    logic sel;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rnd_pix(), rnd_pix(), rnd_pix());
    for (int i = 0; i < 200; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      sel = ($urandom_range(0, 9) != 0);
      step(v, sel, rnd_pix(), rnd_pix(), rnd_pix());
      compared++;
      if (int'(o_data) !== m_out) begin
        mismatched++;
        $display("FAIL random%0d: o_data=%0d expected %0d", i, o_data, m_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_center_tap();
    test_ones();
    test_extremes();
    test_stall();
    test_reload();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/conv_engine.md
# conv_engine

Streaming 3x3 signed 2D-convolution engine for the image-filter datapath. Fed one 3-pixel column per cycle from three line memories (or from the microcontroller GPIO while loading the kernel), it returns one fixed-point output word per accepted image column. It sits between the line BRAMs and the result BRAM.

## Interface
- BIT_LEN, 8: width of kernel coefficients and pixels (signed two's complement).
- CONV_LEN, 20: internal accumulator width (2·BIT_LEN + 4).
- CONV_LPOS, 13: output word width; `o_data` = accumulator[CONV_LEN-1 -: CONV_LPOS].
- M_LEN, 3: kernel/window dimension (only 3 supported).
- CLK100MHZ  in  1  single system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  column-valid strobe; nothing advances while low.
- i_selecK_I  in  1  0 = kernel load, 1 = image stream.
- i_dato0 / i_dato1 / i_dato2  in  BIT_LEN each  signed column; dato0 = row 0 (top), dato2 = row 2.
- o_data  out  CONV_LPOS  signed convolution result, registered.

## Operation
- Kernel load (i_valid=1, i_selecK_I=0): kernel shifts one column per cycle: K[c0]←K[c1], K[c1]←K[c2], K[c2]←{dato0,dato1,dato2}. Three loads fill it; extra loads keep shifting. The image pipeline holds.
- Image stream (i_valid=1, i_selecK_I=1): window shifts identically (W[c2] = newest column). The 9 products W[r][c]·K[r][c] are signed BIT_LEN×BIT_LEN to 2·BIT_LEN, then sign-extended and summed in CONV_LEN bits. No overflow is possible for 3x3 at 8 bits.
- Output: `o_data` = sum[19:7] (arithmetic truncation toward −∞, i.e. kernel treated as Q0.7).
- Kernel is retained across any number of image columns until reloaded or reset.
- i_valid=0: every register (kernel, window, pipeline, `o_data`) holds.
- Window contents before three columns have arrived are whatever was shifted in (zeros after reset). No internal output-valid flag; downstream counts columns.

## Timing
- Reset (async assert, sync-safe release): kernel, window, pipeline and `o_data` = 0 immediately.
- Pipeline has 2 register stages after the window: products register, then sum/`o_data` register. Both advance only on i_valid=1 with i_selecK_I=1.
- Column sampled at edge k (completing window W) gives `o_data`(W) after edge k+2, provided i_valid stays high.
- Switching i_selecK_I mid-stream: pipeline freezes during loads. The new kernel affects only products computed after the load.
- Reset mid-stream discards everything; the kernel must be reloaded.

## Configuration
- CONV_ROUND_EN defined: before truncation add 2^(CONV_LEN-CONV_LPOS-1) = 64 (round half up). If the rounded value exceeds the max positive CONV_LPOS-bit value, saturate to 0x0FFF.
- CONV_ROUND_EN undefined: plain truncation as in Operation.

## Structure
- Package conv_pkg holds BIT_LEN, CONV_LEN, CONV_LPOS, M_LEN defaults, the rounding constant, and the signed pixel/coefficient/accumulator typedefs.
- One sub-module, conv_mac3: 3-tap column dot product (3 signed multiplies plus partial sum). Instantiated 3×, with the top summing the three partials.

## Test plan
- Reset: assert i_reset asynchronously mid-stream → `o_data` = 0 without a clock edge; kernel cleared (all-ones image then yields 0).
- Center tap: load kernel columns (0,0,0), (0,64,0), (0,0,0); stream columns (0,0,0), (0,100,0), (0,0,0) → `o_data` = 50 two edges after the third column.
- All-ones kernel with pixels all 127 → sum 1143, `o_data` = 8 (9 with CONV_ROUND_EN).
- Extremes: kernel all 0x80 (−128) with pixels −128 → 1152; with pixels 127 → −1143 (0x1B89).
- Stall: drop i_valid for 5 cycles between columns → `o_data` holds; result is identical to an unstalled run.
- Kernel reload mid-stream: switch to kernel all 0 for 3 load cycles, resume → after 2 further image columns `o_data` = 0.
